// File: rtl/add_seq_pkg.sv
// Shared constants and state encoding for the byte-serial add sequencer.
package add_seq_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder_8bit.sv
// Shared 8-bit ripple-carry adder datapath: sum/carry of two bytes plus carry-in.
module full_adder_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};

endmodule

// File: rtl/byte_serial_add_seq.sv
// Byte-serial wide adder: one byte per clock through a shared 8-bit adder,
// LSB byte first, carry registered between bytes, start/done handshake.
// Optional subtraction (A-B) is compiled in when SERIAL_SUB_EN is defined.
module byte_serial_add_seq
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum_out,
  output logic                  cout_out,
  output logic                  ovf_out
);

  localparam int W     = 8 * NBYTES;
  localparam int CNT_W = $clog2(NBYTES) + 1;

  state_e           r_state, w_state_nxt;
  logic [W-1:0]     r_a, r_b, r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;

  logic [BYTE_W-1:0] w_a_byte, w_b_byte, w_sum_byte;
  logic              w_cout, w_last, w_ovf;
  logic [W+7:0]      w_shift;
  logic [W-1:0]      w_acc_nxt;

`ifdef SERIAL_SUB_EN
  logic r_sub;
  assign w_b_byte = r_b[BYTE_W-1:0] ^ {BYTE_W{r_sub}};
`else
  logic w_unused_op_sub;
  assign w_unused_op_sub = op_sub;
  assign w_b_byte        = r_b[BYTE_W-1:0];
`endif

  // Operands shift right so the active byte is always at bit 0.
  assign w_a_byte = r_a[BYTE_W-1:0];
  assign w_last   = (r_cnt == CNT_W'(NBYTES - 1));

  full_adder_8bit u_add (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_sum_byte),
    .o_cout (w_cout)
  );

  // Result bytes enter at the top; after NBYTES shifts byte 0 sits at the LSB.
  assign w_shift   = {w_sum_byte, r_acc};
  assign w_acc_nxt = w_shift[W+7:8];

  // Signed overflow judged on the MSB byte's sign bits, using the effective B.
  assign w_ovf = (w_a_byte[7] == w_b_byte[7]) && (w_sum_byte[7] != w_a_byte[7]);

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-byte processing and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      ovf_out  <= 1'b0;
`ifdef SERIAL_SUB_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef SERIAL_SUB_EN
            r_sub   <= op_sub;
            r_carry <= op_sub ? 1'b1 : cin;
`else
            r_carry <= cin;
`endif
          end
        end
        RUN: begin
          r_a     <= r_a >> BYTE_W;
          r_b     <= r_b >> BYTE_W;
          r_acc   <= w_acc_nxt;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            sum_out  <= w_acc_nxt;
            cout_out <= w_cout;
            ovf_out  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
module tb_byte_serial_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout_out, ovf_out;
  logic [W-1:0] sum_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         sub;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb[$];

  byte_serial_add_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out),
    .cout_out(cout_out), .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation, scramble inputs during RUN, then check latency,
  // result (popped from the scoreboard), done width and result hold.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s,
                       input logic [W-1:0] esum, input logic eco, input logic eov);
    int   lat;
    exp_t e;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; op_sub = s; start = 1'b1;
    sb.push_back('{esum, eco, eov});
    @(negedge clk);
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; cin = ~c; op_sub = ~s;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s timeout: no done after %0d cycles, required done", name, lat);
      void'(sb.pop_front());
      return;
    end
    chk({name, " latency"}, 64'(lat), 64'(NB + 1));
    e = sb.pop_front();
    chk({name, " sum"}, 64'(sum_out), 64'(e.sum));
    chk({name, " cout"}, 64'(cout_out), 64'(e.co));
    chk({name, " ovf"}, 64'(ovf_out), 64'(e.ov));
    @(negedge clk);
    chk({name, " done pulse width"}, 64'(done), 64'(0));
    chk({name, " idle after"}, 64'(busy), 64'(0));
    chk({name, " sum held"}, 64'(sum_out), 64'(e.sum));
  endtask

  initial begin
    vec_t vt[$];
    int   ndone, nbusy;

    vt.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0});
    vt.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vt.push_back('{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1});
    vt.push_back('{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0});
    vt.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
    vt.push_back('{32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0});
    vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
`ifdef SERIAL_SUB_EN
    vt.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
    vt.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
    vt.push_back('{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0});
`else
    vt.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0});
`endif

    // Reset state.
    #2;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset sum", 64'(sum_out), 64'(0));
    chk("reset cout", 64'(cout_out), 64'(0));
    chk("reset ovf", 64'(ovf_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i])
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].c, vt[i].sub,
            vt[i].sum, vt[i].co, vt[i].ov);

    // Second start while busy must be dropped.
    @(negedge clk);
    a_in = 32'h00000010; b_in = 32'h00000020; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
    sb.push_back('{32'h00000030, 1'b0, 1'b0});
    ndone = 0; nbusy = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin a_in = 32'hAAAAAAAA; b_in = 32'h11111111; start = 1'b1; end
      else start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        exp_t e;
        ndone++;
        chk("busy-start latency", 64'(i), 64'(NB + 1));
        e = sb.pop_front();
        chk("busy-start sum", 64'(sum_out), 64'(e.sum));
        chk("busy-start cout", 64'(cout_out), 64'(e.co));
      end
    end
    chk("busy-start done count", 64'(ndone), 64'(1));
    chk("busy-start busy cycles", 64'(nbusy), 64'(NB + 1));
    sb.delete();

    // Reset asserted mid-operation.
    @(negedge clk);
    a_in = 32'hFFFFFFFF; b_in = 32'h00000001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 64'(busy), 64'(0));
    chk("midreset done", 64'(done), 64'(0));
    chk("midreset sum", 64'(sum_out), 64'(0));
    chk("midreset cout", 64'(cout_out), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midreset no done/busy", 64'(ndone), 64'(0));
    do_op("post-reset", 32'h01010101, 32'h02020202, 1'b0, 1'b0, 32'h03030303, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
